// File: rtl/gb_cpu_alu16_seq.sv
// 16-bit arithmetic sequencer (ADD HL,rr / INC rr / DEC rr / ADD SP,e8) built on the shared 8-bit ALU.
// Optional macro GB_CPU_IDU_FASTPATH_EN: INC16/DEC16 bypass the ALU via a dedicated 16-bit incrementer.
package gb_cpu_alu_pkg;
    typedef struct packed {
        logic z;
        logic n;
        logic h;
        logic c;
    } alu_flags_t;

    typedef enum logic [3:0] {
        ALU_NOP = 4'd0,
        ALU_ADD = 4'd1,
        ALU_ADC = 4'd2,
        ALU_SUB = 4'd3,
        ALU_SBC = 4'd4,
        ALU_AND = 4'd5,
        ALU_XOR = 4'd6,
        ALU_OR  = 4'd7,
        ALU_CP  = 4'd8
    } alu_opcode_t;

    typedef struct packed {
        alu_opcode_t opcode;
        logic [7:0]  operand_a;
        logic [7:0]  operand_b;
    } alu_instruction_t;
endpackage

module gb_cpu_alu16_seq
    import gb_cpu_alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [15:0]      op_a,
    input  logic [15:0]      op_b,
    input  alu_flags_t       flags_in,
    output logic             busy,
    output logic             done,
    output logic [15:0]      result,
    output alu_flags_t       flags_out,
    output logic             alu_req,
    input  logic             alu_gnt,
    output alu_instruction_t alu_instr,
    output alu_flags_t       alu_flags_i,
    input  logic [7:0]       alu_out,
    input  alu_flags_t       alu_flags_o
);
    localparam logic [1:0] OP_ADD16 = 2'b00;
    localparam logic [1:0] OP_INC16 = 2'b01;
    localparam logic [1:0] OP_DEC16 = 2'b10;
    localparam logic [1:0] OP_ADDSP = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

    state_t     state_q, state_d;
    logic [1:0] op_q;
    logic [15:0] a_q, b_q;
    alu_flags_t fin_q;
    logic [7:0] res_lo_q;
    logic       lo_c_q, lo_h_q;
    logic [15:0] result_q;
    alu_flags_t flags_q;

    logic [7:0] b_lo, b_hi;
    alu_flags_t flags_hi;
    logic       fast_op;
    logic       unused_ok;

    assign unused_ok = &{1'b0, alu_flags_o.z, alu_flags_o.n};

`ifdef GB_CPU_IDU_FASTPATH_EN
    assign fast_op = (op == OP_INC16) || (op == OP_DEC16);
`else
    assign fast_op = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = fast_op ? S_DONE : S_LO;
            S_LO:    if (alu_gnt) state_d = S_HI;
            S_HI:    if (alu_gnt) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Second-operand bytes for the low (ADD) and high (ADC) micro-steps.
    always_comb begin
        b_lo = b_q[7:0];
        b_hi = b_q[15:8];
        case (op_q)
            OP_INC16: begin b_lo = 8'h01; b_hi = 8'h00; end
            OP_DEC16: begin b_lo = 8'hFF; b_hi = 8'hFF; end
            OP_ADDSP: begin b_lo = b_q[7:0]; b_hi = {8{b_q[7]}}; end
            default:  begin b_lo = b_q[7:0]; b_hi = b_q[15:8]; end
        endcase
    end

    always_comb begin
        flags_hi = fin_q;
        case (op_q)
            OP_ADD16: flags_hi = '{z: fin_q.z, n: 1'b0, h: alu_flags_o.h, c: alu_flags_o.c};
            OP_ADDSP: flags_hi = '{z: 1'b0, n: 1'b0, h: lo_h_q, c: lo_c_q};
            default:  flags_hi = fin_q;
        endcase
    end

    always_comb begin
        busy        = (state_q != S_IDLE);
        done        = (state_q == S_DONE);
        alu_req     = (state_q == S_LO) || (state_q == S_HI);
        alu_instr   = '{opcode: ALU_NOP, operand_a: 8'h00, operand_b: 8'h00};
        alu_flags_i = '0;
        case (state_q)
            S_LO: begin
                alu_instr     = '{opcode: ALU_ADD, operand_a: a_q[7:0], operand_b: b_lo};
                alu_flags_i   = fin_q;
                alu_flags_i.c = 1'b0;
            end
            S_HI: begin
                alu_instr     = '{opcode: ALU_ADC, operand_a: a_q[15:8], operand_b: b_hi};
                alu_flags_i   = fin_q;
                alu_flags_i.c = lo_c_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= OP_ADD16;
            a_q      <= 16'h0000;
            b_q      <= 16'h0000;
            fin_q    <= '0;
            res_lo_q <= 8'h00;
            lo_c_q   <= 1'b0;
            lo_h_q   <= 1'b0;
            result_q <= 16'h0000;
            flags_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        a_q   <= op_a;
                        b_q   <= op_b;
                        fin_q <= flags_in;
`ifdef GB_CPU_IDU_FASTPATH_EN
                        if (fast_op) begin
                            result_q <= (op == OP_INC16) ? op_a + 16'd1 : op_a - 16'd1;
                            flags_q  <= flags_in;
                        end
`endif
                    end
                end
                S_LO: begin
                    if (alu_gnt) begin
                        res_lo_q <= alu_out;
                        lo_c_q   <= alu_flags_o.c;
                        lo_h_q   <= alu_flags_o.h;
                    end
                end
                S_HI: begin
                    if (alu_gnt) begin
                        result_q <= {alu_out, res_lo_q};
                        flags_q  <= flags_hi;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result    = result_q;
    assign flags_out = flags_q;
endmodule

// File: tb/tb_gb_cpu_alu16_seq.sv
// Randomized and directed bench for gb_cpu_alu16_seq with an 8-bit ALU responder and a 16-bit arithmetic reference.
module tb_gb_cpu_alu16_seq;
    import gb_cpu_alu_pkg::*;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_INC = 2'b01;
    localparam logic [1:0] OP_DEC = 2'b10;
    localparam logic [1:0] OP_ASP = 2'b11;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [1:0]       op;
    logic [15:0]      op_a, op_b;
    alu_flags_t       flags_in;
    logic             busy, done, alu_req, alu_gnt;
    logic [15:0]      result;
    alu_flags_t       flags_out, alu_flags_i, alu_flags_o;
    alu_instruction_t alu_instr;
    logic [7:0]       alu_out;

    int checks = 0;
    int errors = 0;

    gb_cpu_alu16_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
        .flags_in(flags_in), .busy(busy), .done(done), .result(result), .flags_out(flags_out),
        .alu_req(alu_req), .alu_gnt(alu_gnt), .alu_instr(alu_instr), .alu_flags_i(alu_flags_i),
        .alu_out(alu_out), .alu_flags_o(alu_flags_o)
    );

    always #5 clk = ~clk;

    // Shared 8-bit ALU: only ADD/ADC matter here.
    logic [8:0] alu_sum;
    logic [4:0] alu_hsum;
    logic       alu_cin;
    always_comb begin
        alu_cin     = (alu_instr.opcode == ALU_ADC) ? alu_flags_i.c : 1'b0;
        alu_sum     = {1'b0, alu_instr.operand_a} + {1'b0, alu_instr.operand_b} + {8'd0, alu_cin};
        alu_hsum    = {1'b0, alu_instr.operand_a[3:0]} + {1'b0, alu_instr.operand_b[3:0]} + {4'd0, alu_cin};
        alu_out     = 8'h00;
        alu_flags_o = '0;
        if (alu_instr.opcode == ALU_ADD || alu_instr.opcode == ALU_ADC) begin
            alu_out     = alu_sum[7:0];
            alu_flags_o = '{z: (alu_sum[7:0] == 8'h00), n: 1'b0, h: alu_hsum[4], c: alu_sum[8]};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_fast(input logic [1:0] o);
`ifdef GB_CPU_IDU_FASTPATH_EN
        return (o == OP_INC) || (o == OP_DEC);
`else
        return (o == 2'b11) && (o == 2'b00);
`endif
    endfunction

    // Reference: plain 16-bit arithmetic and the SM83 flag rules.
    function automatic void ref_model(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                                      input alu_flags_t f, output logic [15:0] r, output alu_flags_t fl,
                                      output logic [7:0] blo, output logic [7:0] bhi, output logic loc);
        int ai, bi, e, s;
        ai = int'(a);
        bi = int'(b);
        fl = f;
        case (o)
            OP_ADD: begin
                s   = ai + bi;
                fl  = '{z: f.z, n: 1'b0, h: ((ai & 'hFFF) + (bi & 'hFFF)) > 'hFFF, c: s > 'hFFFF};
                blo = b[7:0];
                bhi = b[15:8];
            end
            OP_INC: begin
                s   = ai + 1;
                blo = 8'h01;
                bhi = 8'h00;
            end
            OP_DEC: begin
                s   = ai + 65535;
                blo = 8'hFF;
                bhi = 8'hFF;
            end
            default: begin
                e   = int'($signed(b[7:0]));
                s   = ai + e + 65536;
                fl  = '{z: 1'b0, n: 1'b0, h: ((ai & 15) + (bi & 15)) > 15, c: ((ai & 255) + (bi & 255)) > 255};
                blo = b[7:0];
                bhi = {8{b[7]}};
            end
        endcase
        r   = s[15:0];
        loc = ((ai & 255) + int'(blo)) > 255;
    endfunction

    task automatic run_op(input string tag, input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                          input alu_flags_t f, input int lo_st, input int hi_st, input bit spam);
        logic [15:0] er;
        alu_flags_t ef;
        logic [7:0] blo, bhi;
        logic loc;
        int cyc, lo_n, hi_n, exp_cyc;
        bit req_seen, req_drop, fast;
        alu_instruction_t ref_i;
        alu_flags_t ref_f;
        ref_model(o, a, b, f, er, ef, blo, bhi, loc);
        fast    = is_fast(o);
        exp_cyc = fast ? 0 : 2 + lo_st + hi_st;
        @(negedge clk);
        start = 1'b1; op = o; op_a = a; op_b = b; flags_in = f; alu_gnt = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cyc = 0; lo_n = 0; hi_n = 0; req_seen = 0; req_drop = 0;
        ref_i = '0; ref_f = '0;
        while (!done && cyc < 80) begin
            if (alu_req) req_seen = 1; else req_drop = 1;
            if (alu_instr.opcode == ALU_ADD) begin
                if (lo_n == 0) begin
                    chk({tag, "_lo_a"},  {24'd0, alu_instr.operand_a}, {24'd0, a[7:0]});
                    chk({tag, "_lo_b"},  {24'd0, alu_instr.operand_b}, {24'd0, blo});
                    chk({tag, "_lo_ci"}, {31'd0, alu_flags_i.c}, 32'd0);
                    ref_i = alu_instr; ref_f = alu_flags_i;
                end else begin
                    chk({tag, "_lo_stable"}, {12'd0, alu_instr, ref_f}, {12'd0, ref_i, alu_flags_i});
                end
                lo_n++;
                alu_gnt = (lo_n > lo_st);
            end else if (alu_instr.opcode == ALU_ADC) begin
                if (hi_n == 0) begin
                    chk({tag, "_hi_a"},  {24'd0, alu_instr.operand_a}, {24'd0, a[15:8]});
                    chk({tag, "_hi_b"},  {24'd0, alu_instr.operand_b}, {24'd0, bhi});
                    chk({tag, "_hi_ci"}, {31'd0, alu_flags_i.c}, {31'd0, loc});
                    ref_i = alu_instr;
                end else begin
                    chk({tag, "_hi_stable"}, {12'd0, alu_instr}, {12'd0, ref_i});
                end
                hi_n++;
                alu_gnt = (hi_n > hi_st);
            end else begin
                alu_gnt = 1'b0;
            end
            if (spam) begin
                start = 1'b1; op = 2'($urandom_range(0, 3)); op_a = 16'($urandom); op_b = 16'($urandom);
                flags_in = alu_flags_t'(4'($urandom_range(0, 15)));
            end
            @(negedge clk);
            cyc++;
        end
        alu_gnt = 1'b0;
        start   = 1'b0;
        chk({tag, "_done"},    {31'd0, done}, 32'd1);
        chk({tag, "_latency"}, cyc, exp_cyc);
        chk({tag, "_busy"},    {31'd0, busy}, 32'd1);
        chk({tag, "_req_off"}, {31'd0, alu_req}, 32'd0);
        chk({tag, "_nop"},     {12'd0, alu_instr}, 32'd0);
        chk({tag, "_result"},  {16'd0, result}, {16'd0, er});
        chk({tag, "_flags"},   {28'd0, flags_out}, {28'd0, ef});
        if (fast) chk({tag, "_no_req"}, {31'd0, req_seen}, 32'd0);
        else      chk({tag, "_req_held"}, {31'd0, req_drop}, 32'd0);
        @(negedge clk);
        chk({tag, "_idle_busy"}, {30'd0, busy, done}, 32'd0);
        chk({tag, "_hold"}, {12'd0, result, flags_out}, {12'd0, er, ef});
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op = 2'b00; op_a = 16'h0; op_b = 16'h0;
        flags_in = '0; alu_gnt = 1'b0;
        #7;
        chk("rst_ctrl",   {29'd0, busy, done, alu_req}, 32'd0);
        chk("rst_result", {12'd0, result, flags_out}, 32'd0);
        chk("rst_instr",  {12'd0, alu_instr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("add_h",     OP_ADD, 16'h0FFF, 16'h0001, alu_flags_t'(4'b1001), 0, 0, 0);
        run_op("add_wrap",  OP_ADD, 16'hFFFF, 16'h0001, alu_flags_t'(4'b0000), 0, 0, 0);
        run_op("asp_neg",   OP_ASP, 16'hFFF8, 16'h00FF, alu_flags_t'(4'b1111), 0, 0, 0);
        run_op("asp_pos",   OP_ASP, 16'h0000, 16'h0008, alu_flags_t'(4'b1111), 0, 0, 0);
        run_op("inc_wrap",  OP_INC, 16'hFFFF, 16'h1234, alu_flags_t'(4'b1011), 0, 0, 0);
        run_op("dec_wrap",  OP_DEC, 16'h0000, 16'h5678, alu_flags_t'(4'b1011), 0, 0, 0);
        run_op("add_stall", OP_ADD, 16'h8A5C, 16'h75B7, alu_flags_t'(4'b0110), 4, 2, 1);

        for (int i = 0; i < 40; i++) begin
            run_op("rnd", 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom),
                   alu_flags_t'(4'($urandom_range(0, 15))),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        run_op("pre_rst", OP_ADD, 16'h1234, 16'h1111, alu_flags_t'(4'b0000), 0, 0, 0);
        @(negedge clk);
        start = 1'b1; op = OP_ADD; op_a = 16'h4321; op_b = 16'h0101; flags_in = '0; alu_gnt = 1'b0;
        @(negedge clk);
        start = 1'b0; alu_gnt = 1'b1;
        @(negedge clk);
        alu_gnt = 1'b0;
        chk("rst_in_hi", {28'd0, alu_instr.opcode}, {28'd0, ALU_ADC});
        #2 rst_n = 1'b0;
        #1;
        chk("async_ctrl",   {29'd0, busy, done, alu_req}, 32'd0);
        chk("async_result", {12'd0, result, flags_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst", OP_ADD, 16'h0F0F, 16'h00F1, alu_flags_t'(4'b1000), 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/gb_cpu_alu16_seq.md
Name: gb_cpu_alu16_seq

Overview:
- Multi-cycle sequencer that executes the 16-bit arithmetic group on the shared 8-bit CPU ALU: ADD HL,rr; INC rr; DEC rr; ADD SP,e8 (also LD HL,SP+e8).
- Each operation runs as two ALU micro-steps: low byte, then high byte with carry-in.
- Requests the ALU from the CPU's ALU arbiter, waits for grant, and produces the 16-bit result plus SM83 flags.
- Sits between the instruction decoder/control unit and the ALU instance.

Parameters:
- none.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request pulse; accepted only in IDLE
- op  in  2  operation: 00 ADD16, 01 INC16, 10 DEC16, 11 ADDSP
- op_a  in  16  first operand (HL or SP, or rr for INC/DEC)
- op_b  in  16  second operand (rr for ADD16; bits [7:0] signed e8 for ADDSP; ignored for INC/DEC)
- flags_in  in  alu_flags_t  current F register (Z,N,H,C)
- busy  out  1  high from accepted start until done cycle inclusive
- done  out  1  one-cycle completion pulse
- result  out  16  registered result; holds until next accepted start
- flags_out  out  alu_flags_t  registered resulting flags; holds like result
- alu_req  out  1  ALU ownership request
- alu_gnt  in  1  ALU granted this cycle
- alu_instr  out  alu_instruction_t  opcode/operand_a/operand_b driven to ALU; ALU_NOP with zero operands when not in LO/HI
- alu_flags_i  out  alu_flags_t  flags fed to ALU
- alu_out  in  8  ALU result
- alu_flags_o  in  alu_flags_t  ALU flags

Behaviour:
- Reset (async, any state, including mid-operation): state=IDLE; busy=0, done=0, alu_req=0, result=16'h0000, flags_out=4'b0; captured operands cleared.
- FSM states: IDLE -> LO -> HI -> DONE -> IDLE.
- IDLE:
  - start=1 at a rising edge latches op, op_a, op_b, flags_in and moves to LO.
  - start in any other state is ignored (no queueing).
- LO:
  - alu_req=1.
  - Drives ADD, operand_a=op_a[7:0], operand_b=B_lo, alu_flags_i.C=0.
  - Operand mapping, B_lo/B_hi:
    - ADD16: op_b[7:0] / op_b[15:8]
    - INC16: 8'h01 / 8'h00
    - DEC16: 8'hFF / 8'hFF
    - ADDSP: op_b[7:0] / {8{op_b[7]}}
  - On an edge with alu_gnt=1: register alu_out into result_lo and alu_flags_o.C/H into lo_c/lo_h; go to HI.
  - alu_gnt=0: stay, all outputs stable (stall of any length).
- HI:
  - alu_req=1.
  - Drives ADC, operand_a=op_a[15:8], operand_b=B_hi, alu_flags_i.C=lo_c.
  - On a granted edge: register result={alu_out, result_lo} and flags_out; go to DONE.
  - alu_req stays high continuously across LO->HI; the arbiter must not regrant elsewhere between steps.
- DONE: done=1, busy=1, alu_req=0 for exactly one cycle, then IDLE. The next start is accepted in IDLE only.
- Flag rules:
  - ADD16: Z=flags_in.Z; N=0; H=ALU H of HI step (carry from bit 11); C=ALU C of HI step (carry from bit 15).
  - INC16/DEC16: flags_out=flags_in unchanged.
  - ADDSP: Z=0; N=0; H=lo_h; C=lo_c (unsigned carries from bits 3 and 7 of the low add).
- Minimum latency: start edge k; LO granted at k+1, HI granted at k+2, done high during the cycle after edge k+2; result valid in that same cycle.
- Wrap-around: 16-bit results are modulo 2^16 (0xFFFF+1 = 0x0000, 0x0000-1 = 0xFFFF).

Optional Feature:
- Macro GB_CPU_IDU_FASTPATH_EN.
- Defined: INC16/DEC16 use a dedicated internal 16-bit incrementer/decrementer.
  - IDLE -> DONE directly; alu_req never asserted; done in the cycle after the start edge.
  - Flags unchanged.
- Undefined: INC16/DEC16 take the LO/HI path through the shared ALU as above. ADD16/ADDSP are identical in both builds.

Test Plan:
- ADD16, op_a=0x0FFF, op_b=0x0001, flags_in Z=1,C=1, gnt tied 1 -> result=0x1000; Z=1, N=0, H=1, C=0; done one cycle after the second grant.
- ADD16, 0xFFFF + 0x0001, flags_in=0 -> result=0x0000; Z=0 (preserved, not computed), H=1, C=1.
- ADDSP, op_a=0xFFF8, op_b[7:0]=0xFF -> result=0xFFF7; Z=0, N=0, H=1, C=1. Repeat with e8=0x08, op_a=0x0000 -> 0x0008, H=0, C=0.
- INC16 0xFFFF -> 0x0000 and DEC16 0x0000 -> 0xFFFF; flags_out==flags_in (F=0xB0 pattern Z,H,C set preserved). With GB_CPU_IDU_FASTPATH_EN: alu_req never high, done one cycle after start.
- ADD16 with alu_gnt low for 4 cycles in LO and 2 cycles in HI -> alu_req held high throughout, alu_instr stable while stalled, done 6 cycles later than the ungranted-free case, correct result; start pulses during busy ignored.
- rst_n deasserted while in HI -> busy, done, alu_req and result go to 0 immediately without a clock; after release, a new ADD16 completes normally.
